// File: rtl/rv_mem_pkg.sv
// Shared constants and types for the data-memory bridge: access-size codes,
// bridge FSM states and bus strobe width.
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned STRB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Halfwords need even addresses, words need word-aligned addresses.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return lo[0];
         default:     return (lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a bus word and sign- or
// zero-extends it according to the load's funct3.
module load_align
   import rv_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] ldata_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    ldata_c = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ldata_c = {24'd0, byte_sel};
         F3_H:    ldata_c = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ldata_c = {16'd0, half_sel};
         default: ldata_c = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges memory-stage loads/stores onto a valid/ready bus, stalling the
// pipeline while a transfer is outstanding and bounding waits with a timeout.
module dmem_bridge
   import rv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read_en,
   input  logic              i_write_en,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [2:0]        i_funct3,
   output logic              o_stall,
   output logic [31:0]       o_rdata,
   output logic              o_misalign,
   output logic              o_fault,
   output logic              o_bus_valid,
   output logic              o_bus_we,
   output logic [31:0]       o_bus_addr,
   output logic [31:0]       o_bus_wdata,
   output logic [STRB_W-1:0] o_bus_wstrb,
   input  logic              i_bus_ready,
   input  logic [31:0]       i_bus_rdata,
   input  logic              i_bus_err
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e            state, state_d;
   logic [CNT_W-1:0]  wait_cnt;
   logic [2:0]        f3_q;
   logic [1:0]        alo_q;
   logic              req_c, misal_c, timeout_c;
   logic [STRB_W-1:0] strb_c;
   logic [31:0]       wdata_c;
   logic [31:0]       ldata_c;

   assign req_c     = i_read_en | i_write_en;
   assign misal_c   = is_misaligned(i_funct3, i_addr[1:0]);
   assign timeout_c = (state == ST_REQ) && !i_bus_ready &&
                      (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign o_stall   = ((state == ST_IDLE) && req_c && !misal_c) || (state == ST_REQ);

   // Store lane steering: replicate the datum across lanes, strobe the target.
   always_comb begin
      strb_c  = 4'b1111;
      wdata_c = i_wdata;
      case (i_funct3)
         F3_B, F3_BU: begin
            strb_c  = 4'b0001 << i_addr[1:0];
            wdata_c = {4{i_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            strb_c  = 4'b0011 << {i_addr[1], 1'b0};
            wdata_c = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   load_align u_load_align (
      .rdata   (i_bus_rdata),
      .addr_lo (alo_q),
      .funct3  (f3_q),
      .ldata_c (ldata_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   // DONE never accepts: the memory stage still shows the finished request.
   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE: if (req_c && !misal_c) state_d = ST_REQ;
         ST_REQ:  if (i_bus_ready || timeout_c) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_bus_valid <= 1'b0;
         o_bus_we    <= 1'b0;
         o_bus_addr  <= 32'd0;
         o_bus_wdata <= 32'd0;
         o_bus_wstrb <= '0;
         o_rdata     <= 32'd0;
         o_fault     <= 1'b0;
         o_misalign  <= 1'b0;
         f3_q        <= 3'd0;
         alo_q       <= 2'd0;
         wait_cnt    <= '0;
      end else begin
         o_fault    <= 1'b0;
         o_misalign <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_c && misal_c) begin
                  o_misalign <= 1'b1;
               end else if (req_c) begin
                  o_bus_valid <= 1'b1;
                  o_bus_we    <= i_write_en;
                  o_bus_addr  <= {i_addr[31:2], 2'b00};
                  o_bus_wdata <= wdata_c;
                  o_bus_wstrb <= i_write_en ? strb_c : '0;
                  f3_q        <= i_funct3;
                  alo_q       <= i_addr[1:0];
                  wait_cnt    <= '0;
               end
            end
            ST_REQ: begin
               if (i_bus_ready) begin
                  o_bus_valid <= 1'b0;
                  if (i_bus_err) begin
                     o_rdata <= 32'd0;
                     o_fault <= 1'b1;
                  end else if (!o_bus_we) begin
                     o_rdata <= ldata_c;
                  end
               end else if (timeout_c) begin
                  o_bus_valid <= 1'b0;
                  o_rdata     <= 32'd0;
                  o_fault     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge (TIMEOUT = 4) with hand-computed
// expectations; also exercises load_align standalone.
module tb_dmem_bridge;
   import rv_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        re, we;
   logic [31:0] addr, wdata;
   logic [2:0]  f3;
   logic        stall, misalign, fault;
   logic [31:0] rdata;
   logic        bvalid, bwe;
   logic [31:0] baddr, bwdata;
   logic [3:0]  bstrb;
   logic        ready, err;
   logic [31:0] brd;

   logic [31:0] ref_rd;
   logic [1:0]  ref_lo;
   logic [2:0]  ref_f3;
   logic [31:0] ref_out;

   int tests_run = 0;
   int tests_failed = 0;

   int          r_stall, r_valid;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [3:0]  r_strb;
   logic        r_we, r_stable, r_fault;

   always #5 clk = ~clk;

   dmem_bridge #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .i_read_en(re), .i_write_en(we), .i_addr(addr),
      .i_wdata(wdata), .i_funct3(f3), .o_stall(stall), .o_rdata(rdata),
      .o_misalign(misalign), .o_fault(fault), .o_bus_valid(bvalid),
      .o_bus_we(bwe), .o_bus_addr(baddr), .o_bus_wdata(bwdata),
      .o_bus_wstrb(bstrb), .i_bus_ready(ready), .i_bus_rdata(brd),
      .i_bus_err(err)
   );

   load_align u_ref (.rdata(ref_rd), .addr_lo(ref_lo), .funct3(ref_f3), .ldata_c(ref_out));

   // Presents a request and plays the bus; returns at the first stall-free cycle.
   task automatic run_access(input logic t_re, input logic t_we, input logic [31:0] t_addr,
                             input logic [31:0] t_wdata, input logic [2:0] t_f3, input int dly,
                             input logic [31:0] t_brd, input logic t_err);
      bit done = 0;
      @(negedge clk);
      re = t_re; we = t_we; addr = t_addr; wdata = t_wdata; f3 = t_f3;
      brd = t_brd; err = t_err; ready = (dly == 0);
      r_stall = 0; r_valid = 0; r_stable = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (!stall) begin
            r_fault = fault; r_rdata = rdata; done = 1;
            break;
         end
         r_stall++;
         if (bvalid) begin
            if (r_valid == 0) begin
               r_addr = baddr; r_wdata = bwdata; r_strb = bstrb; r_we = bwe;
            end else if (baddr !== r_addr || bwdata !== r_wdata || bstrb !== r_strb || bwe !== r_we) begin
               r_stable = 1'b0;
            end
            r_valid++;
            ready = (r_valid > dly);
         end
      end
      if (!done) begin
         tests_run++; tests_failed++;
         $display("FAIL access_wait: stall never released (addr %h)", t_addr);
      end
   endtask

   task automatic release_req();
      @(negedge clk);
      re = 1'b0; we = 1'b0; ready = 1'b0; err = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; f3 = F3_W;
      ready = 1'b0; err = 1'b0; brd = '0;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if ({stall, bvalid, fault, misalign, bwe} !== 5'b0) begin
         tests_failed++; $display("FAIL reset_ctrl: got %b exp 00000", {stall, bvalid, fault, misalign, bwe});
      end
      tests_run++;
      if ({rdata, baddr, bwdata, bstrb} !== 100'd0) begin
         tests_failed++; $display("FAIL reset_data: rdata %h addr %h wdata %h strb %b", rdata, baddr, bwdata, bstrb);
      end
      rst = 1'b0;
   endtask

   task automatic test_lw();
      run_access(1'b1, 1'b0, 32'h100, 32'h0, F3_W, 0, 32'hDEADBEEF, 1'b0);
      tests_run++;
      if (r_stall !== 2) begin tests_failed++; $display("FAIL lw_stall: got %0d exp 2", r_stall); end
      tests_run++;
      if (r_addr !== 32'h100 || r_strb !== 4'b0000 || r_we !== 1'b0) begin
         tests_failed++; $display("FAIL lw_bus: addr %h strb %b we %b exp 00000100 0000 0", r_addr, r_strb, r_we);
      end
      tests_run++;
      if (r_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_rdata: got %h exp deadbeef", r_rdata); end
      release_req();
      tests_run++;
      if (bvalid !== 1'b0 || stall !== 1'b0) begin
         tests_failed++; $display("FAIL lw_no_reissue: valid %b stall %b exp 0 0", bvalid, stall);
      end
   endtask

   task automatic test_load_ext();
      logic [2:0]  tf3 [3] = '{F3_B, F3_BU, F3_H};
      logic [31:0] tad [3] = '{32'h103, 32'h103, 32'h102};
      logic [31:0] tex [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
      for (int i = 0; i < 3; i++) begin
         run_access(1'b1, 1'b0, tad[i], 32'h0, tf3[i], 0, 32'h80FF1234, 1'b0);
         tests_run++;
         if (r_rdata !== tex[i]) begin
            tests_failed++; $display("FAIL load_ext[%0d]: got %h exp %h", i, r_rdata, tex[i]);
         end
         release_req();
         ref_rd = 32'h80FF1234; ref_lo = tad[i][1:0]; ref_f3 = tf3[i];
         #1;
         tests_run++;
         if (ref_out !== tex[i]) begin
            tests_failed++; $display("FAIL load_align[%0d]: got %h exp %h", i, ref_out, tex[i]);
         end
      end
   endtask

   task automatic test_store_half();
      run_access(1'b0, 1'b1, 32'h202, 32'h0000ABCD, F3_H, 3, 32'h0, 1'b0);
      tests_run++;
      if (r_strb !== 4'b1100 || r_wdata !== 32'hABCDABCD || r_addr !== 32'h200 || r_we !== 1'b1) begin
         tests_failed++; $display("FAIL sh_bus: strb %b wdata %h addr %h we %b", r_strb, r_wdata, r_addr, r_we);
      end
      tests_run++;
      if (r_valid !== 4 || r_stall !== 5 || r_stable !== 1'b1) begin
         tests_failed++; $display("FAIL sh_timing: valid %0d stall %0d stable %b exp 4 5 1", r_valid, r_stall, r_stable);
      end
      tests_run++;
      if (r_rdata !== 32'hFFFF80FF) begin tests_failed++; $display("FAIL sh_rdata_kept: got %h exp ffff80ff", r_rdata); end
      release_req();
   endtask

   task automatic test_misalign();
      run_access(1'b1, 1'b0, 32'h101, 32'h0, F3_W, 0, 32'h0, 1'b0);
      tests_run++;
      if (r_stall !== 0 || r_valid !== 0) begin
         tests_failed++; $display("FAIL mis_stall: stall %0d valid %0d exp 0 0", r_stall, r_valid);
      end
      release_req();
      tests_run++;
      if (misalign !== 1'b1 || bvalid !== 1'b0) begin
         tests_failed++; $display("FAIL mis_pulse: misalign %b valid %b exp 1 0", misalign, bvalid);
      end
      @(negedge clk); #1;
      tests_run++;
      if (misalign !== 1'b0 || bvalid !== 1'b0) begin
         tests_failed++; $display("FAIL mis_once: misalign %b valid %b exp 0 0", misalign, bvalid);
      end
   endtask

   task automatic test_both_en();
      run_access(1'b1, 1'b1, 32'h10, 32'h12345678, F3_W, 0, 32'hCAFEF00D, 1'b0);
      tests_run++;
      if (r_we !== 1'b1 || r_strb !== 4'b1111 || r_wdata !== 32'h12345678 || r_addr !== 32'h10) begin
         tests_failed++; $display("FAIL both_bus: we %b strb %b wdata %h addr %h", r_we, r_strb, r_wdata, r_addr);
      end
      tests_run++;
      if (r_rdata !== 32'hFFFF80FF) begin tests_failed++; $display("FAIL both_rdata: got %h exp ffff80ff", r_rdata); end
      release_req();
   endtask

   task automatic test_store_byte();
      run_access(1'b0, 1'b1, 32'h101, 32'h00000011, F3_B, 0, 32'h0, 1'b0);
      tests_run++;
      if (r_strb !== 4'b0010 || r_wdata !== 32'h11111111 || r_addr !== 32'h100) begin
         tests_failed++; $display("FAIL sb_bus: strb %b wdata %h addr %h exp 0010 11111111 00000100", r_strb, r_wdata, r_addr);
      end
      release_req();
   endtask

   task automatic test_bus_err();
      run_access(1'b1, 1'b0, 32'h500, 32'h0, F3_W, 1, 32'h55555555, 1'b1);
      tests_run++;
      if (r_fault !== 1'b1 || r_rdata !== 32'h0 || r_stall !== 3) begin
         tests_failed++; $display("FAIL err_resp: fault %b rdata %h stall %0d exp 1 0 3", r_fault, r_rdata, r_stall);
      end
      release_req();
      tests_run++;
      if (fault !== 1'b0) begin tests_failed++; $display("FAIL err_pulse: fault %b exp 0", fault); end
   endtask

   task automatic test_timeout();
      run_access(1'b1, 1'b0, 32'h102, 32'h0, F3_HU, 0, 32'h80FF1234, 1'b0);
      tests_run++;
      if (r_rdata !== 32'h000080FF) begin tests_failed++; $display("FAIL lhu_rdata: got %h exp 000080ff", r_rdata); end
      release_req();
      run_access(1'b1, 1'b0, 32'h300, 32'h0, F3_W, 100, 32'h0, 1'b0);
      tests_run++;
      if (r_valid !== 4 || r_stall !== 5) begin
         tests_failed++; $display("FAIL to_len: valid %0d stall %0d exp 4 5", r_valid, r_stall);
      end
      tests_run++;
      if (r_fault !== 1'b1 || r_rdata !== 32'h0 || bvalid !== 1'b0) begin
         tests_failed++; $display("FAIL to_done: fault %b rdata %h valid %b exp 1 0 0", r_fault, r_rdata, bvalid);
      end
      release_req();
      tests_run++;
      if (fault !== 1'b0 || stall !== 1'b0) begin
         tests_failed++; $display("FAIL to_release: fault %b stall %b exp 0 0", fault, stall);
      end
   endtask

   task automatic test_reset_mid_req();
      run_access(1'b1, 1'b0, 32'h100, 32'h0, F3_W, 0, 32'hDEADBEEF, 1'b0);
      release_req();
      @(negedge clk);
      re = 1'b1; addr = 32'h400; f3 = F3_W; ready = 1'b0;
      @(negedge clk); #1;
      tests_run++;
      if (bvalid !== 1'b1 || stall !== 1'b1) begin
         tests_failed++; $display("FAIL rst_req1: valid %b stall %b exp 1 1", bvalid, stall);
      end
      @(negedge clk);
      rst = 1'b1; re = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (bvalid !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || baddr !== 32'h0 || bstrb !== 4'b0) begin
         tests_failed++; $display("FAIL rst_mid: valid %b stall %b rdata %h addr %h strb %b", bvalid, stall, rdata, baddr, bstrb);
      end
      @(negedge clk); #1;
      tests_run++;
      if (bvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_stay_idle: valid %b exp 0", bvalid); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_store_half();
      test_misalign();
      test_both_en();
      test_store_byte();
      test_bus_err();
      test_timeout();
      test_reset_mid_req();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the core's memory-access stage and a valid/ready data bus. It completes every load and store the pipeline initiates, and drives `ex_stall` to freeze the pipeline while a transfer is outstanding. It also generates byte strobes, aligns and sign-extends load data, flags misaligned accesses, and bounds bus waits with a timeout.

## Interface
Parameters:
- `TIMEOUT`, default 255: the maximum number of `REQ` cycles before the transfer is abandoned; must be ≥ 1.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_read_en` input 1: load request from the memory stage.
- `i_write_en` input 1: store request from the memory stage; wins if both are set.
- `i_addr` input 32: byte address (the memory-stage result).
- `i_wdata` input 32: store data (memory-stage rs2).
- `i_funct3` input 3: access size/sign. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU; any other code is treated as W.
- `o_stall` output 1: to the core's `ex_stall`; freezes the pipeline.
- `o_rdata` output 32: aligned, extended load data.
- `o_misalign` output 1: one-cycle pulse on a misaligned request.
- `o_fault` output 1: one-cycle pulse on bus error or timeout.
- `o_bus_valid` output 1: bus request valid.
- `o_bus_we` output 1: 1 = write.
- `o_bus_addr` output 32: word address, with bits [1:0] = 0.
- `o_bus_wdata` output 32: lane-replicated store data.
- `o_bus_wstrb` output 4: byte enables; 0000 on reads.
- `i_bus_ready` input 1: bus accepts and completes the request.
- `i_bus_rdata` input 32: read word, valid when ready is high.
- `i_bus_err` input 1: error response, sampled only with ready.

## Operation
- FSM has three states: `IDLE`, `REQ`, `DONE`. Reset puts the FSM in `IDLE`.
- `req = i_read_en | i_write_en`.
- A request is misaligned when either holds:
  - H/HU with `addr[0]` = 1;
  - W with `addr[1:0]` ≠ 0.
- `IDLE`:
  - If `req` and misaligned: pulse `o_misalign`, do no bus transfer and no stall, stay in `IDLE`.
  - If `req` and aligned: capture `we`, `addr`, strobes, data and `funct3`; go to `REQ`.
- `REQ`:
  - `o_bus_valid` = 1, and all bus outputs are held stable until handshake.
  - On `ready` with `err` = 0: go to `DONE`. On a read, capture the extracted load result from `i_bus_rdata`.
  - On `ready` with `err` = 1: go to `DONE`, set `o_rdata` to 0, pulse `o_fault`.
  - When the wait counter reaches `TIMEOUT` without `ready`: drop `valid`, go to `DONE`, set `o_rdata` to 0, pulse `o_fault`.
- `DONE`: always go to `IDLE`. The memory stage still presents the same request in this cycle and it must not be re-issued.
- Stores:
  - SB: `wstrb = 0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - SH: `wstrb = 0011 << {addr[1],1'b0}`, `wdata = {2{wdata[15:0]}}`.
  - SW: `wstrb = 1111`, `wdata` unchanged.
- Loads: select the byte at `addr[1:0]` or the halfword at `addr[1]`. Sign-extend for B/H, zero-extend for BU/HU.
- `o_rdata` holds its last value until the next completed read. Stores do not change it.

## Timing
- `o_stall` is combinational: `(IDLE & req & ~misaligned) | REQ`. It is 0 in `DONE`, so the pipeline advances on the edge that ends `DONE`.
- With zero-wait memory (`ready` tied to 1), each access stalls 2 cycles (`IDLE`, `REQ`), then 1 cycle in `DONE` with `o_rdata` valid.
- Each cycle of `ready` = 0 in `REQ` adds one stall cycle.
- Timeout: the counter clears on entry to `REQ` and increments each `REQ` cycle without `ready`. When it equals `TIMEOUT`, exit to `DONE`, so `REQ` lasts exactly `TIMEOUT` cycles.
- Any cycle with `rst` high forces, at that edge:
  - state to `IDLE`;
  - `o_bus_valid`, `o_stall`, `o_fault`, `o_misalign` to 0;
  - `o_rdata`, `o_bus_addr`, `o_bus_wdata`, `o_bus_wstrb`, `o_bus_we` to 0.
  This applies mid-`REQ` as well: the request is abandoned without handshake.
- `o_fault` and `o_misalign` are high for exactly one cycle per event.

## Structure
- Package `rv_mem_pkg` holds:
  - the funct3 size constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the FSM state enum;
  - the bus strobe width constant.
- Sub-module `load_align`: combinational extract and sign/zero-extend, taking `rdata`, `addr[1:0]` and `funct3`. The bench also reuses it as its reference model.

## Test plan
- LW at 0x100 with ready tied to 1 and `rdata` 0xDEADBEEF → `o_stall` high for 2 cycles, `o_bus_addr` = 0x100, `wstrb` = 0000, then `DONE` with `o_rdata` = 0xDEADBEEF.
- LB at 0x103 with `rdata` 0x80FF_1234 → `o_rdata` = 0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SH at 0x202 with `wdata` 0x0000ABCD and ready delayed 3 cycles → `wstrb` = 1100, `wdata` = 0xABCDABCD, `valid` and `addr` stable for 4 cycles, 5 stall cycles total.
- LW at 0x101 → `o_misalign` pulses for 1 cycle, `o_bus_valid` never rises, `o_stall` stays 0.
- With `TIMEOUT` = 4 and ready held at 0 → `REQ` lasts 4 cycles, `o_fault` pulses in `DONE`, `o_rdata` = 0, stall releases. A second case asserts `rst` in the 2nd `REQ` cycle → next cycle is `IDLE` with `valid` = 0 and stall = 0.
- `i_read_en` and `i_write_en` both high, SW at 0x10 → a write is issued with `wstrb` = 1111, and `o_rdata` is unchanged.
